argmax_frame_controller: RTL and testbench

Sequencing controller that computes the signed argmax over one frame of up to `2**INDEX_WIDTH` values, delivered 16 lanes per beat. It owns the beat counter, the running max/argmax registers and the 16-input parallel signed argmax datapath. It accepts a frame-start command with a runtime beat count, takes input beats under a valid/ready handshake, and presents one registered result under a second valid/ready handshake. It sits between the feature/logit stream and the downstream decision logic.

---
 rtl/argmax_frame_controller.sv | 127 ++++++++++++
 tb/tb_argmax_frame_controller.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_frame_controller.sv
// Frame-level signed argmax controller: 16 lanes per beat, running max/argmax, result handshake.
// Optional abort port enabled by defining ARGMAX_CTRL_ABORT_EN.
module argmax_frame_controller #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned INDEX_WIDTH = 8,
  localparam int unsigned MAX_BEATS  = 2 ** INDEX_WIDTH / 16,
  localparam int unsigned NBW        = $clog2(MAX_BEATS) + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NBW-1:0]                 num_beats,
  output logic                           busy,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [15:0][WIDTH-1:0]         in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [WIDTH-1:0]        out_max,
  output logic [INDEX_WIDTH-1:0]         out_argmax
`ifdef ARGMAX_CTRL_ABORT_EN
  ,
  input  logic                           abort
`endif
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e                   state_q, state_d;
  logic [NBW-1:0]           cnt_q, cnt_d;
  logic [NBW-1:0]           beats_q, beats_d;
  logic signed [WIDTH-1:0]  max_q, max_d;
  logic [INDEX_WIDTH-1:0]   arg_q, arg_d;

  logic signed [WIDTH-1:0]  lane_max;
  logic [3:0]               lane_idx;
  logic [INDEX_WIDTH-1:0]   beat_idx;
  logic [NBW-1:0]           beats_eff;
  logic                     abort_act;

`ifdef ARGMAX_CTRL_ABORT_EN
  assign abort_act = abort;
`else
  assign abort_act = 1'b0;
`endif

  // Strict compare keeps the lowest lane on ties.
  always_comb begin
    lane_max = $signed(in[0]);
    lane_idx = 4'd0;
    for (int i = 1; i < 16; i++) begin
      if ($signed(in[i]) > lane_max) begin
        lane_max = $signed(in[i]);
        lane_idx = 4'(i);
      end
    end
  end

  assign beat_idx  = (INDEX_WIDTH'(cnt_q) << 4) + INDEX_WIDTH'(lane_idx);
  assign beats_eff = (num_beats == '0 || num_beats > NBW'(MAX_BEATS)) ? NBW'(MAX_BEATS)
                                                                       : num_beats;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    beats_d   = beats_q;
    max_d     = max_q;
    arg_d     = arg_q;
    busy      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          beats_d = beats_eff;
          cnt_d   = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        busy     = 1'b1;
        in_ready = ~abort_act;
        if (abort_act) begin
          state_d = StIdle;
        end else if (in_valid) begin
          // First beat loads unconditionally so nothing leaks from the previous frame.
          if (cnt_q == '0 || lane_max > max_q) begin
            max_d = lane_max;
            arg_d = beat_idx;
          end
          cnt_d = cnt_q + NBW'(1);
          if (cnt_q == beats_q - NBW'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = ~abort_act;
        if (abort_act || out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      beats_q <= NBW'(MAX_BEATS);
      max_q   <= {1'b1, {(WIDTH - 1){1'b0}}};
      arg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
      max_q   <= max_d;
      arg_q   <= arg_d;
    end
  end

  assign out_max    = max_q;
  assign out_argmax = arg_q;

endmodule

// File: tb/tb_argmax_frame_controller.sv
// Randomized bench for argmax_frame_controller against a first-occurrence argmax model.
// Abort scenario is exercised when ARGMAX_CTRL_ABORT_EN is defined.
module tb_argmax_frame_controller;

  localparam int W   = 8;
  localparam int IW  = 8;
  localparam int MB  = 16;
  localparam int NBW = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [NBW-1:0]       num_beats;
  logic                 busy;
  logic                 in_valid;
  logic                 in_ready;
  logic [15:0][W-1:0]   din;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [W-1:0]  out_max;
  logic [IW-1:0]        out_argmax;
`ifdef ARGMAX_CTRL_ABORT_EN
  logic                 abort;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int vals[256];

  argmax_frame_controller #(
    .WIDTH      (W),
    .INDEX_WIDTH(IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_beats (num_beats),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_max   (out_max),
    .out_argmax(out_argmax)
`ifdef ARGMAX_CTRL_ABORT_EN
    ,
    .abort     (abort)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void fill(input int lo, input int hi);
    for (int k = 0; k < 256; k++) vals[k] = lo + int'($urandom_range(hi - lo));
  endfunction

  task automatic drive_beat(input int b);
    for (int i = 0; i < 16; i++) din[i] = vals[b * 16 + i][7:0];
  endtask

  // Reference: maximum over the frame, earliest index wins.
  task automatic model(input int eff, output int mx, output int ix);
    mx = -129;
    ix = 0;
    for (int k = 0; k < eff * 16; k++) begin
      if (vals[k] > mx) begin
        mx = vals[k];
        ix = k;
      end
    end
  endtask

  task automatic run_frame(input int nb, input bit toggle, input int hold, input string tag);
    int eff, mx, ix;
    eff = (nb == 0 || nb > MB) ? MB : nb;
    model(eff, mx, ix);
    check({tag, ":idle_busy"}, int'(busy), 0);
    start     = 1'b1;
    num_beats = nb[NBW-1:0];
    @(negedge clk);
    start = 1'b0;
    check({tag, ":busy"}, int'(busy), 1);
    for (int b = 0; b < eff; b++) begin
      if (toggle) begin
        in_valid = 1'b0;
        din      = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
      end
      check({tag, ":in_ready"}, int'(in_ready), 1);
      check({tag, ":early_valid"}, int'(out_valid), 0);
      drive_beat(b);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({tag, ":out_valid"}, int'(out_valid), 1);
    check({tag, ":in_ready_done"}, int'(in_ready), 0);
    check({tag, ":max"}, int'(out_max), mx);
    check({tag, ":argmax"}, int'(out_argmax), ix);
    out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start     = 1'b1;
      num_beats = NBW'($urandom_range(20));
      @(negedge clk);
      check({tag, ":hold_valid"}, int'(out_valid), 1);
      check({tag, ":hold_max"}, int'(out_max), mx);
      check({tag, ":hold_argmax"}, int'(out_argmax), ix);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ":release_valid"}, int'(out_valid), 0);
    check({tag, ":release_busy"}, int'(busy), 0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    num_beats = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din       = '0;
`ifdef ARGMAX_CTRL_ABORT_EN
    abort     = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst:busy", int'(busy), 0);
    check("rst:in_ready", int'(in_ready), 0);
    check("rst:out_valid", int'(out_valid), 0);
    check("rst:max", int'(out_max), -128);
    check("rst:argmax", int'(out_argmax), 0);
    rst = 1'b0;
    @(negedge clk);

    // Basic: single 100 at beat 2 lane 5.
    fill(-128, 50);
    vals[37] = 100;
    run_frame(4, 1'b0, 0, "basic");

    // All minimum values across a full frame.
    for (int k = 0; k < 256; k++) vals[k] = -128;
    run_frame(16, 1'b0, 0, "allmin");

    // Cross-beat tie: earliest beat must win.
    fill(-128, 6);
    vals[19] = 7;
    vals[48] = 7;
    run_frame(4, 1'b0, 0, "tie");

    // Back-to-back: no carry-over of a larger previous max.
    fill(-128, 89);
    vals[21] = 90;
    run_frame(3, 1'b0, 0, "frameA");
    for (int k = 0; k < 256; k++) vals[k] = -5;
    run_frame(2, 1'b1, 0, "frameB");

    // Backpressure with start asserted while waiting.
    fill(-128, 127);
    run_frame(5, 1'b0, 10, "bp");

    // Reset mid-frame, then a clean frame.
    fill(-128, 127);
    start     = 1'b1;
    num_beats = 5'd4;
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      drive_beat(b);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst:busy", int'(busy), 0);
    check("midrst:in_ready", int'(in_ready), 0);
    check("midrst:out_valid", int'(out_valid), 0);
    check("midrst:max", int'(out_max), -128);
    check("midrst:argmax", int'(out_argmax), 0);
    fill(-128, 127);
    run_frame(4, 1'b0, 0, "postrst");

    // Clamping of zero and oversized beat counts.
    fill(-128, 127);
    run_frame(0, 1'b0, 0, "clamp0");
    fill(-20, 20);
    run_frame(20, 1'b1, 0, "clamp20");

`ifdef ARGMAX_CTRL_ABORT_EN
    fill(-128, 127);
    start     = 1'b1;
    num_beats = 5'd2;
    @(negedge clk);
    start = 1'b0;
    drive_beat(0);
    in_valid = 1'b1;
    @(negedge clk);
    drive_beat(1);
    abort = 1'b1;
    #1;
    check("abort:in_ready", int'(in_ready), 0);
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort:out_valid", int'(out_valid), 0);
    check("abort:busy", int'(busy), 0);
    fill(-128, 127);
    run_frame(3, 1'b0, 0, "postabort");
`endif

    // Randomized frames: mixed value ranges, beat counts, valid gaps and stalls.
    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(1) == 0) fill(-128, 127);
      else fill(-3, 3);
      run_frame(int'($urandom_range(20)), 1'($urandom_range(1)), int'($urandom_range(3)),
                $sformatf("rnd%0d", f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
